// File: rtl/fifo_rr_drain_pkg.sv
// fifo_rr_drain_pkg
//   Shared definitions for the round-robin FIFO drain controller:
//   controller state encoding, burst counter width and the helper that
//   locates one channel's word inside the packed fifoData bus.
package fifo_rr_drain_pkg;

    // Controller states: IDLE arbitrates, BURST drains the granted channel.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Burst counter is wide enough for any MAX_BURST in 1..255.
    localparam int BURST_CNT_W = 8;

    // Channel c occupies fifoData[c*width +: width].
    function automatic int chanLsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_pick.sv
// rr_priority_pick
//   Purely combinational round-robin picker. Starting just after the last
//   granted channel and wrapping, it returns the first eligible channel.
//   Ports:
//     eligible  [NUM_CH]   per-channel request (present and enabled)
//     last      [LOG2_CH]  previously granted channel
//     pickValid            at least one channel is eligible
//     pickIdx   [LOG2_CH]  chosen channel
module rr_priority_pick
    import fifo_rr_drain_pkg::*;
#(
    parameter int LOG2_CH = 2
) (
    input  logic [(2**LOG2_CH)-1:0] eligible,
    input  logic [LOG2_CH-1:0]      last,
    output logic                    pickValid,
    output logic [LOG2_CH-1:0]      pickIdx
);

    localparam int NUM_CH = 2 ** LOG2_CH;

    logic [NUM_CH-1:0]  rotated;
    logic [LOG2_CH-1:0] offset;
    logic               found;

    // Rotate so that bit 0 is the channel after 'last', take the lowest set
    // bit, then rotate the answer back by adding it to last+1. Index
    // arithmetic is done in LOG2_CH bits so the wrap is free.
    always_comb begin
        rotated = '0;
        offset  = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            rotated[i] = eligible[LOG2_CH'(int'(last) + 1 + i)];
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = LOG2_CH'(i);
            end
        end
        pickValid = found;
        pickIdx   = last + LOG2_CH'(1) + offset;
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain
//   Round-robin drain controller sharing one valid/ready output stream
//   between NUM_CH shift-register FIFOs. One channel is granted at a time
//   for at most MAX_BURST words; its pops are registered into outData.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     chEnable      per-channel enable mask (disabled channels never granted)
//     fifoPresent   registered dataPresent of each FIFO
//     fifoData      packed head words, channel c at [c*WIDTH +: WIDTH]
//     fifoRead      one-hot (or zero) pop strobes, combinational
//     outData       registered output word
//     outValid      outData holds an unconsumed word
//     outReady      consumer takes outData this cycle
//     grantValid    high while a channel is being drained
//     grantIdx      current or most recently granted channel
module fifo_rr_drain
    import fifo_rr_drain_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LOG2_CH   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [(2**LOG2_CH)-1:0]         chEnable,
    input  logic [(2**LOG2_CH)-1:0]         fifoPresent,
    input  logic [(2**LOG2_CH)*WIDTH-1:0]   fifoData,
    output logic [(2**LOG2_CH)-1:0]         fifoRead,
    output logic [WIDTH-1:0]                outData,
    output logic                            outValid,
    input  logic                            outReady,
    output logic                            grantValid,
    output logic [LOG2_CH-1:0]              grantIdx
);

    localparam int NUM_CH = 2 ** LOG2_CH;

    state_t                  state;
    logic [BURST_CNT_W-1:0]  burstCount;
    logic [NUM_CH-1:0]       eligible;
    logic                    grantEligible;
    logic                    load;
    logic                    lastWord;
    logic                    pickValid;
    logic [LOG2_CH-1:0]      pickIdx;

    // A word can be popped only from the granted channel, and only when the
    // output register is empty or being emptied in the same cycle.
    always_comb begin
        eligible      = fifoPresent & chEnable;
        grantEligible = eligible[grantIdx];
        load          = (state == ST_BURST) && grantEligible && (!outValid || outReady);
        lastWord      = (burstCount == BURST_CNT_W'(MAX_BURST - 1));
        fifoRead           = '0;
        fifoRead[grantIdx] = load;
    end

    rr_priority_pick #(
        .LOG2_CH (LOG2_CH)
    ) u_pick (
        .eligible  (eligible),
        .last      (grantIdx),
        .pickValid (pickValid),
        .pickIdx   (pickIdx)
    );

    // Controller FSM plus output register. Reset leaves grantIdx on the last
    // channel so the first search starts at channel 0. A burst ends on its
    // final pop or as soon as the granted channel stops being eligible; in
    // the latter case no read happens that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            burstCount <= '0;
            grantIdx   <= LOG2_CH'(NUM_CH - 1);
            grantValid <= 1'b0;
            outData    <= '0;
            outValid   <= 1'b0;
        end else begin
            if (load) begin
                outData    <= fifoData[chanLsb(int'(grantIdx), WIDTH) +: WIDTH];
                outValid   <= 1'b1;
                burstCount <= burstCount + BURST_CNT_W'(1);
            end else if (outValid && outReady) begin
                outValid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pickValid) begin
                        grantIdx   <= pickIdx;
                        burstCount <= '0;
                        state      <= ST_BURST;
                        grantValid <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if ((load && lastWord) || !grantEligible) begin
                        state      <= ST_IDLE;
                        grantValid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    grantValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain
//   Directed bench for fifo_rr_drain (WIDTH=8, four channels, MAX_BURST=2)
//   with a small behavioural FIFO bank driving the head data and flags.
module tb_fifo_rr_drain;

    localparam int WIDTH     = 8;
    localparam int LOG2_CH   = 2;
    localparam int NUM_CH    = 4;
    localparam int MAX_BURST = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       chEnable;
    logic [NUM_CH-1:0]       fifoPresent;
    logic [NUM_CH*WIDTH-1:0] fifoData;
    logic [NUM_CH-1:0]       fifoRead;
    logic [WIDTH-1:0]        outData;
    logic                    outValid;
    logic                    outReady;
    logic                    grantValid;
    logic [LOG2_CH-1:0]      grantIdx;

    // Behavioural FIFO bank: push port driven by the stimulus, pops from DUT.
    logic                    pushEn;
    int                      pushCh;
    logic [WIDTH-1:0]        pushWord;
    logic [WIDTH-1:0]        mem [NUM_CH][16];
    int                      cnt [NUM_CH];

    int assertCount;
    int failCount;

    // Stream capture filled by collectStream.
    logic [WIDTH-1:0] gotWords [16];
    int               gotGrants [16];
    int               gotWordCnt;
    int               gotGrantCnt;
    int               minIdle;
    int               maxIdle;

    fifo_rr_drain #(
        .WIDTH     (WIDTH),
        .LOG2_CH   (LOG2_CH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .chEnable    (chEnable),
        .fifoPresent (fifoPresent),
        .fifoData    (fifoData),
        .fifoRead    (fifoRead),
        .outData     (outData),
        .outValid    (outValid),
        .outReady    (outReady),
        .grantValid  (grantValid),
        .grantIdx    (grantIdx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shift-register FIFO model: pop and push take effect at the clock edge,
    // so dataPresent and head behave as registered outputs.
    always @(posedge clk) begin
        int n;
        for (int c = 0; c < NUM_CH; c++) begin
            n = cnt[c];
            if (fifoRead[c] && n > 0) begin
                for (int i = 0; i < 15; i++) mem[c][i] <= mem[c][i + 1];
                n = n - 1;
            end
            if (pushEn && pushCh == c && n < 16) begin
                mem[c][n] <= pushWord;
                n = n + 1;
            end
            cnt[c] <= n;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            fifoPresent[c]              = (cnt[c] != 0);
            fifoData[c*WIDTH +: WIDTH]  = mem[c][0];
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push one word into a FIFO; called at a falling edge, returns one cycle later.
    task automatic applyStimulus(input int ch, input logic [WIDTH-1:0] word);
        pushCh   = ch;
        pushWord = word;
        pushEn   = 1'b1;
        @(negedge clk);
        pushEn   = 1'b0;
    endtask

    // Record consumed words, grant order and idle gaps between grants until
    // nWords are seen and nothing is left to drain, or the budget expires.
    task automatic collectStream(input int nWords, input int maxCycles);
        int   cycles;
        int   idleRun;
        logic prevGrant;
        gotWordCnt  = 0;
        gotGrantCnt = 0;
        minIdle     = 1000;
        maxIdle     = 0;
        idleRun     = 0;
        prevGrant   = 1'b0;
        cycles      = 0;
        while (cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            if (outValid && outReady) begin
                if (gotWordCnt < 16) gotWords[gotWordCnt] = outData;
                gotWordCnt++;
            end
            if (grantValid && !prevGrant) begin
                if (gotGrantCnt > 0) begin
                    if (idleRun < minIdle) minIdle = idleRun;
                    if (idleRun > maxIdle) maxIdle = idleRun;
                end
                if (gotGrantCnt < 16) gotGrants[gotGrantCnt] = int'(grantIdx);
                gotGrantCnt++;
            end
            if (!grantValid) idleRun++;
            else idleRun = 0;
            prevGrant = grantValid;
            if (gotWordCnt >= nWords && !grantValid && ((fifoPresent & chEnable) == '0)) break;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] expRr [9];
        int               expRrGrant [6];
        assertCount = 0;
        failCount   = 0;
        rst      = 1'b0;
        chEnable = '0;
        outReady = 1'b1;
        pushEn   = 1'b0;
        pushCh   = 0;
        pushWord = '0;

        // ---------------- Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_outValid",   32'(outValid),   32'd0);
        checkOutput("rst_outData",    32'(outData),    32'h00);
        checkOutput("rst_grantValid", 32'(grantValid), 32'd0);
        checkOutput("rst_grantIdx",   32'(grantIdx),   32'd3);
        checkOutput("rst_fifoRead",   32'(fifoRead),   32'h0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- Single source latency and burst limit
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
        chEnable = 4'b1111;
        @(negedge clk);
        checkOutput("lat_grantValid_e1", 32'(grantValid), 32'd1);
        checkOutput("lat_grantIdx_e1",   32'(grantIdx),   32'd0);
        checkOutput("lat_fifoRead_c1",   32'(fifoRead),   32'h1);
        checkOutput("lat_outValid_e1",   32'(outValid),   32'd0);
        @(negedge clk);
        checkOutput("lat_outValid_e2",   32'(outValid),   32'd1);
        checkOutput("lat_word0",         32'(outData),    32'h11);
        checkOutput("lat_fifoRead_c2",   32'(fifoRead),   32'h1);
        @(negedge clk);
        checkOutput("lat_word1",         32'(outData),    32'h22);
        checkOutput("lat_burstEnd",      32'(grantValid), 32'd0);
        checkOutput("lat_noReadIdle",    32'(fifoRead),   32'h0);
        @(negedge clk);
        checkOutput("lat_bubbleEmpty",   32'(outValid),   32'd0);
        checkOutput("lat_regrant",       32'(grantValid), 32'd1);
        checkOutput("lat_regrantIdx",    32'(grantIdx),   32'd0);
        @(negedge clk);
        checkOutput("lat_word2",         32'(outData),    32'h33);
        checkOutput("lat_word2Valid",    32'(outValid),   32'd1);
        checkOutput("lat_emptyNoRead",   32'(fifoRead),   32'h0);
        @(negedge clk);
        checkOutput("lat_idleAfterEmpty", 32'(grantValid), 32'd0);
        checkOutput("lat_outDrained",     32'(outValid),   32'd0);

        // ---------------- Round-robin with burst limit (reset restores ch0 priority)
        chEnable = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'hA0 + 8'(i));
            applyStimulus(1, 8'hB0 + 8'(i));
            applyStimulus(3, 8'hD0 + 8'(i));
        end
        expRr      = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hD0, 8'hD1, 8'hA2, 8'hB2, 8'hD2};
        expRrGrant = '{0, 1, 3, 0, 1, 3};
        chEnable = 4'b1111;
        collectStream(9, 80);
        checkOutput("rr_wordCount",  32'(gotWordCnt),  32'd9);
        for (int i = 0; i < 9; i++) checkOutput($sformatf("rr_word%0d", i), 32'(gotWords[i]), 32'(expRr[i]));
        checkOutput("rr_grantCount", 32'(gotGrantCnt), 32'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("rr_grant%0d", i), 32'(gotGrants[i]), 32'(expRrGrant[i]));
        checkOutput("rr_minIdle", 32'(minIdle), 32'd1);
        checkOutput("rr_maxIdle", 32'(maxIdle), 32'd1);

        // ---------------- Backpressure on channel 1
        chEnable = '0;
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h41 + 8'(i));
        chEnable = 4'b1111;
        @(negedge clk);
        checkOutput("bp_grantIdx", 32'(grantIdx), 32'd1);
        @(negedge clk);
        checkOutput("bp_firstValid", 32'(outValid), 32'd1);
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_stallRead%0d", i), 32'(fifoRead), 32'h0);
            checkOutput($sformatf("bp_holdData%0d", i),  32'(outData),  32'h41);
            @(negedge clk);
        end
        checkOutput("bp_burstCount", 32'(dut.burstCount), 32'd1);
        checkOutput("bp_fifoLeft",   32'(cnt[1]),         32'd3);
        checkOutput("bp_grantHeld",  32'(grantValid),     32'd1);
        outReady = 1'b1;
        collectStream(3, 40);
        checkOutput("bp_wordCount", 32'(gotWordCnt),  32'd3);
        checkOutput("bp_word0",     32'(gotWords[0]), 32'h42);
        checkOutput("bp_word1",     32'(gotWords[1]), 32'h43);
        checkOutput("bp_word2",     32'(gotWords[2]), 32'h44);

        // ---------------- Disable channel 2 during its second read
        chEnable = '0;
        for (int i = 0; i < 4; i++) applyStimulus(2, 8'hC1 + 8'(i));
        chEnable = 4'b1111;
        @(negedge clk);
        checkOutput("dis_grantIdx", 32'(grantIdx), 32'd2);
        checkOutput("dis_read1",    32'(fifoRead), 32'h4);
        @(negedge clk);
        checkOutput("dis_word0",    32'(outData),  32'hC1);
        checkOutput("dis_read2",    32'(fifoRead), 32'h4);
        chEnable = 4'b1011;
        #1;
        checkOutput("dis_readSuppressed", 32'(fifoRead), 32'h0);
        @(negedge clk);
        checkOutput("dis_idle",      32'(grantValid), 32'd0);
        checkOutput("dis_oneWord",   32'(outValid),   32'd0);
        checkOutput("dis_fifoLeft",  32'(cnt[2]),     32'd3);
        @(negedge clk);
        checkOutput("dis_stillIdle", 32'(grantValid), 32'd0);
        checkOutput("dis_noReads",   32'(fifoRead),   32'h0);

        // ---------------- Asynchronous reset mid-burst
        chEnable = 4'b1111;
        @(negedge clk);
        checkOutput("ar_grantIdx", 32'(grantIdx), 32'd2);
        @(negedge clk);
        checkOutput("ar_valid",    32'(outValid), 32'd1);
        checkOutput("ar_word",     32'(outData),  32'hC2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_outValidCleared",   32'(outValid),   32'd0);
        checkOutput("ar_fifoReadCleared",   32'(fifoRead),   32'h0);
        checkOutput("ar_grantValidCleared", 32'(grantValid), 32'd0);
        @(negedge clk);
        chEnable = '0;
        applyStimulus(0, 8'h5A);
        rst = 1'b1;
        chEnable = 4'b1111;
        collectStream(3, 40);
        checkOutput("ar_firstGrant", 32'(gotGrants[0]), 32'd0);
        checkOutput("ar_wordCount",  32'(gotWordCnt),   32'd3);
        checkOutput("ar_word0",      32'(gotWords[0]),  32'h5A);
        checkOutput("ar_word1",      32'(gotWords[1]),  32'hC3);
        checkOutput("ar_word2",      32'(gotWords[2]),  32'hC4);

        // ---------------- Wrap-around and sole requester re-grant
        chEnable = '0;
        applyStimulus(3, 8'hD5);
        applyStimulus(3, 8'hD6);
        applyStimulus(3, 8'hD7);
        applyStimulus(0, 8'h05);
        applyStimulus(1, 8'h15);
        applyStimulus(2, 8'h25);
        chEnable = 4'b1000;
        collectStream(3, 40);
        checkOutput("wr_soleGrants", 32'(gotGrantCnt), 32'd2);
        checkOutput("wr_soleGrant0", 32'(gotGrants[0]), 32'd3);
        checkOutput("wr_soleGrant1", 32'(gotGrants[1]), 32'd3);
        checkOutput("wr_soleIdle",   32'(maxIdle),      32'd1);
        checkOutput("wr_soleWord2",  32'(gotWords[2]),  32'hD7);
        checkOutput("wr_lastIdx",    32'(grantIdx),     32'd3);
        chEnable = 4'b1111;
        collectStream(3, 40);
        checkOutput("wr_wrapGrant0", 32'(gotGrants[0]), 32'd0);
        checkOutput("wr_wrapGrant1", 32'(gotGrants[1]), 32'd1);
        checkOutput("wr_wrapGrant2", 32'(gotGrants[2]), 32'd2);
        checkOutput("wr_wrapWord0",  32'(gotWords[0]),  32'h05);
        checkOutput("wr_wrapWord1",  32'(gotWords[1]),  32'h15);
        checkOutput("wr_wrapWord2",  32'(gotWords[2]),  32'h25);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Round-robin drain controller that shares one output stream between NUM_CH shift-register FIFOs.
- Each FIFO presents combinational head data plus a registered dataPresent flag, and pops on a 1-clk read strobe.
- The block grants one channel at a time for a bounded burst, issues that channel's read strobes, and registers the popped word into a valid/ready output stage.
- It sits between the per-source FIFO bank and a single downstream consumer, such as a serializer or bus master.

Parameters:
- WIDTH, 8: data word width (must match the FIFO WIDTH).
- LOG2_CH, 2: log2 of channel count; NUM_CH = 2**LOG2_CH.
- MAX_BURST, 4: maximum words popped per grant; range 1..255.

Ports:
- clk  input  1: system clock.
- rst  input  1: reset. One clock; reset is asynchronous and active-low.
- chEnable  input  NUM_CH: per-channel enable mask. A disabled channel is never granted.
- fifoPresent  input  NUM_CH: dataPresent from each FIFO.
- fifoData  input  NUM_CH*WIDTH: head data of each FIFO; channel c occupies bits [c*WIDTH +: WIDTH].
- fifoRead  output  NUM_CH: one-hot (or zero) read strobes, combinational from state and inputs.
- outData  output  WIDTH: registered output word.
- outValid  output  1: outData holds an unconsumed word.
- outReady  input  1: consumer accepts outData this cycle.
- grantValid  output  1: high while in BURST.
- grantIdx  output  LOG2_CH: currently/last granted channel.

Behaviour:
- Reset (rst=0, async): state=IDLE, outValid=0, outData=0, burstCount=0, grantIdx=NUM_CH-1 (channel 0 wins first), grantValid=0, fifoRead=0.
- eligible[c] = fifoPresent[c] & chEnable[c].
- load = (state==BURST) & eligible[grantIdx] & (~outValid | outReady).
- fifoRead[grantIdx] = load; all other bits are 0.
- On load: outData <= fifoData[grantIdx], outValid <= 1, burstCount <= burstCount+1.
- When outValid & outReady & ~load: outValid <= 0.
- The output stage sustains 1 word/clk when outReady is held high.
- IDLE:
  - If any eligible bit is set, pick the first eligible channel searching grantIdx+1, grantIdx+2, ... (mod NUM_CH, wrapping).
  - Register it into grantIdx, clear burstCount, go to BURST.
  - Otherwise stay in IDLE.
  - No reads are issued in IDLE.
- BURST -> IDLE, at the edge where any of the following holds:
  - (a) load occurs and burstCount+1 == MAX_BURST;
  - (b) ~eligible[grantIdx], meaning the FIFO is empty or the channel is disabled; no read is issued that cycle.
- BURST -> BURST otherwise. This includes eligible but stalled by outReady=0: the grant is held and burstCount is unchanged.
- Latency: with the block in IDLE, an output register that is empty or being consumed, and fifoPresent rising before edge 0:
  - grant is registered at edge 1;
  - fifoRead is high in cycle 1;
  - outValid is high after edge 2.
- Pop-every-cycle is legal: the FIFO's dataPresent and head update at the same edge as the read.
- A channel with a sole request is re-granted after one IDLE bubble cycle. Its fairness is bounded by MAX_BURST words per NUM_CH grants.
- chEnable deasserted mid-burst: the burst ends with no read that cycle; the already-registered outData is still delivered.
- MAX_BURST=1: every grant pops exactly one word, then returns to IDLE.
- Reset mid-burst: all state is cleared immediately and any word in the output register is discarded. The FIFOs are reset by their own logic.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_BURST=1'b1), the burst counter width rule (8 bits), and the fifoData channel-slice convention.
- One sub-module, rr_priority_pick. It is purely combinational: inputs eligible[NUM_CH] and last[LOG2_CH]; outputs pickValid and pickIdx. It rotates, priority-encodes, then rotates back.
- The controller FSM, counter and output register stay in fifo_rr_drain.

Test Plan:
- Single source, basic latency and burst limit:
  - Stimulus: after reset, load ch0 FIFO with 0x11,0x22,0x33; outReady=1.
  - Required: grant ch0 at edge 1, outValid from edge 2, data 0x11,0x22,0x33 on consecutive cycles, then IDLE after fifoPresent[0] falls.
- Round-robin with burst limit:
  - Stimulus: MAX_BURST=2; ch0, ch1 and ch3 each hold 3 words (A0..A2, B0..B2, D0..D2).
  - Required output order: A0 A1 B0 B1 D0 D1 A2 B2 D2. Exactly one IDLE cycle between grants; ch2 is never granted.
- Backpressure:
  - Stimulus: ch1 holds 4 words; outReady=0 for 5 cycles after the first outValid.
  - Required: fifoRead stays 0 while stalled, outData holds the first word, burstCount is unchanged; on release, words resume back-to-back with no loss or duplication.
- Disable mid-burst:
  - Stimulus: ch2 holds 4 words; chEnable[2] dropped in the cycle of its 2nd read.
  - Required: that read is suppressed, the state returns to IDLE, only 1 word is output, ch2 keeps 3 words, and no other channel is affected.
- Async reset mid-burst:
  - Stimulus: assert rst=0 between clock edges while outValid=1.
  - Required: outValid, fifoRead and grantValid go to 0 without waiting for a clock edge; after release, channel 0 has first priority again.
- Wrap-around:
  - Stimulus: grantIdx=3 with all channels eligible.
  - Required: the next grant is ch0. With only ch3 eligible, ch3 is re-granted after one IDLE cycle.
